// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags between decoder and ROB.
// Define REGFILE_TRACE_EN to compile commit tracing and a stale-commit simulation check.
module reg_file_rename #(
    parameter int ROB_WIDTH_BIT = 5,
    parameter int NUM_REGS      = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_val,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [4:0]               rename_rd,
    input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    input  logic                     rob_rs1_ready,
    input  logic [31:0]              rob_rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs2_val,
    output logic [31:0]              rs1_val,
    output logic                     rs1_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [31:0]              rs2_val,
    output logic                     rs2_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

    typedef struct packed {
        logic [31:0]              val;
        logic                     dep;
        logic [ROB_WIDTH_BIT-1:0] tag;
    } query_t;

    logic [31:0]              regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic [ROB_WIDTH_BIT-1:0] tag  [NUM_REGS];

    logic commit_en;
    logic rename_en;
    logic commit_frees;

    assign commit_en    = (commit_rd != 5'd0);
    assign rename_en    = (rename_rd != 5'd0) && !clear_in;
    // A younger rename of the same register keeps it busy under its new tag.
    assign commit_frees = commit_en && busy[commit_rd] &&
                          (tag[commit_rd] == commit_rob_id) &&
                          !(rename_en && (rename_rd == commit_rd));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                regs[commit_rd] <= commit_val;
            end
            if (clear_in) begin
                busy <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag[i] <= '0;
                end
            end else begin
                if (commit_frees) begin
                    busy[commit_rd] <= 1'b0;
                end
                if (rename_en) begin
                    busy[rename_rd] <= 1'b1;
                    tag[rename_rd]  <= rename_rob_id;
                end
            end
        end
    end

    // Sources are never bypassed from the same-cycle rename: they precede the destination.
    function automatic query_t resolve(
        input logic [4:0]               rs,
        input logic [31:0]              reg_val,
        input logic                     reg_busy,
        input logic [ROB_WIDTH_BIT-1:0] reg_tag,
        input logic                     rob_ready,
        input logic [31:0]              rob_val,
        input logic [4:0]               c_rd,
        input logic [31:0]              c_val,
        input logic [ROB_WIDTH_BIT-1:0] c_id
    );
        query_t q;
        q = '0;
        if (rs == 5'd0) begin
            q = '0;
        end else if (!reg_busy) begin
            q.val = (c_rd == rs) ? c_val : reg_val;
        end else if ((c_rd == rs) && (c_id == reg_tag)) begin
            q.val = c_val;
        end else if (rob_ready) begin
            q.val = rob_val;
        end else begin
            q.dep = 1'b1;
            q.tag = reg_tag;
        end
        return q;
    endfunction

    query_t q1;
    query_t q2;

    always_comb begin
        q1 = resolve(dec_rs1, regs[dec_rs1], busy[dec_rs1], tag[dec_rs1],
                     rob_rs1_ready, rob_rs1_val, commit_rd, commit_val, commit_rob_id);
        q2 = resolve(dec_rs2, regs[dec_rs2], busy[dec_rs2], tag[dec_rs2],
                     rob_rs2_ready, rob_rs2_val, commit_rd, commit_val, commit_rob_id);
    end

    assign rob_rs1_id = tag[dec_rs1];
    assign rob_rs2_id = tag[dec_rs2];
    assign rs1_val    = q1.val;
    assign rs1_dep    = q1.dep;
    assign rs1_tag    = q1.tag;
    assign rs2_val    = q2.val;
    assign rs2_dep    = q2.dep;
    assign rs2_tag    = q2.tag;

`ifdef REGFILE_TRACE_EN
    always @(posedge clk_in) begin
        if (rst_in && rdy_in && commit_en) begin
            $display("reg x%0d <= %h (rob %0d)", commit_rd, commit_val, commit_rob_id);
            if (!busy[commit_rd] && (tag[commit_rd] != '0) && (tag[commit_rd] != commit_rob_id)) begin
                $error("commit to idle x%0d with stale tag %0d (rob %0d)",
                       commit_rd, tag[commit_rd], commit_rob_id);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: directed scenarios then random traffic vs. a reference model.
module tb_reg_file_rename;

    localparam int RW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_in;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_val;
    logic [RW-1:0] commit_rob_id;
    logic [4:0]    rename_rd;
    logic [RW-1:0] rename_rob_id;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [RW-1:0] rob_rs1_id;
    logic          rob_rs1_ready;
    logic [31:0]   rob_rs1_val;
    logic [RW-1:0] rob_rs2_id;
    logic          rob_rs2_ready;
    logic [31:0]   rob_rs2_val;
    logic [31:0]   rs1_val;
    logic          rs1_dep;
    logic [RW-1:0] rs1_tag;
    logic [31:0]   rs2_val;
    logic          rs2_dep;
    logic [RW-1:0] rs2_tag;

    always #5 clk_in = ~clk_in;

    reg_file_rename #(.ROB_WIDTH_BIT(RW), .NUM_REGS(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .rename_rd(rename_rd), .rename_rob_id(rename_rob_id),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
        .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
        .rs1_val(rs1_val), .rs1_dep(rs1_dep), .rs1_tag(rs1_tag),
        .rs2_val(rs2_val), .rs2_dep(rs2_dep), .rs2_tag(rs2_tag)
    );

    typedef struct {
        string         name;
        logic [31:0]   v1;
        logic          d1;
        logic [RW-1:0] t1;
        logic [RW-1:0] id1;
        logic [31:0]   v2;
        logic          d2;
        logic [RW-1:0] t2;
        logic [RW-1:0] id2;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Architectural view: committed value, pending flag, and producing ROB entry per register.
    logic [31:0]   m_val  [32];
    bit            m_busy [32];
    logic [RW-1:0] m_tag  [32];

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic void expectSrc(input logic [4:0] rs, input logic rob_rdy,
                                      input logic [31:0] rob_v, output logic [31:0] v,
                                      output logic d, output logic [RW-1:0] t);
        v = '0;
        d = 1'b0;
        t = '0;
        if (rs == 5'd0) begin
            v = '0;
        end else if (!m_busy[rs]) begin
            v = (commit_rd == rs) ? commit_val : m_val[rs];
        end else if (commit_rd == rs && commit_rob_id == m_tag[rs]) begin
            v = commit_val;
        end else if (rob_rdy) begin
            v = rob_v;
        end else begin
            d = 1'b1;
            t = m_tag[rs];
        end
    endfunction

    task automatic pushExpect(input string name);
        exp_t e;
        e.name = name;
        expectSrc(dec_rs1, rob_rs1_ready, rob_rs1_val, e.v1, e.d1, e.t1);
        expectSrc(dec_rs2, rob_rs2_ready, rob_rs2_val, e.v2, e.d2, e.t2);
        e.id1 = m_tag[dec_rs1];
        e.id2 = m_tag[dec_rs2];
        sb.push_back(e);
    endtask

    task automatic modelClock();
        if (rst_in && rdy_in) begin
            bit frees;
            frees = (commit_rd != 0) && m_busy[commit_rd] && (m_tag[commit_rd] == commit_rob_id);
            if (commit_rd != 0) m_val[commit_rd] = commit_val;
            if (clear_in) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = '0;
                end
            end else begin
                if (frees) m_busy[commit_rd] = 1'b0;
                if (rename_rd != 0) begin
                    m_busy[rename_rd] = 1'b1;
                    m_tag[rename_rd]  = rename_rob_id;
                end
            end
        end
    endtask

    task automatic applyStimulus(input string name,
                                 input logic [4:0] c_rd, input logic [31:0] c_val, input logic [RW-1:0] c_id,
                                 input logic [4:0] r_rd, input logic [RW-1:0] r_id,
                                 input logic clr, input logic rdy,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic r1_ok, input logic [31:0] r1_v,
                                 input logic r2_ok, input logic [31:0] r2_v);
        commit_rd = c_rd;   commit_val = c_val;  commit_rob_id = c_id;
        rename_rd = r_rd;   rename_rob_id = r_id;
        clear_in = clr;     rdy_in = rdy;
        dec_rs1 = s1;       dec_rs2 = s2;
        rob_rs1_ready = r1_ok; rob_rs1_val = r1_v;
        rob_rs2_ready = r2_ok; rob_rs2_val = r2_v;
        pushExpect(name);
        @(posedge clk_in);
        modelClock();
        #1;
    endtask

    task automatic query(input string name, input logic [4:0] s1, input logic [4:0] s2);
        applyStimulus(name, 0, 0, 0, 0, 0, 0, 1, s1, s2, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle.
    always @(negedge clk_in) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (rs1_val !== e.v1 || rs1_dep !== e.d1 || rs1_tag !== e.t1 || rob_rs1_id !== e.id1 ||
            rs2_val !== e.v2 || rs2_dep !== e.d2 || rs2_tag !== e.t2 || rob_rs2_id !== e.id2) begin
            miscompares++;
            $display("[TB] FAIL %s: got rs1 %h/%b/%0d id%0d rs2 %h/%b/%0d id%0d, required rs1 %h/%b/%0d id%0d rs2 %h/%b/%0d id%0d",
                     e.name, rs1_val, rs1_dep, rs1_tag, rob_rs1_id, rs2_val, rs2_dep, rs2_tag, rob_rs2_id,
                     e.v1, e.d1, e.t1, e.id1, e.v2, e.d2, e.t2, e.id2);
        end
    endtask

    task automatic asyncReset(input logic [4:0] s1, input logic [4:0] s2);
        #2;
        rst_in = 1'b0;
        modelReset();
        commit_rd = 0; rename_rd = 0; clear_in = 0;
        rob_rs1_ready = 0; rob_rs2_ready = 0;
        dec_rs1 = s1; dec_rs2 = s2;
        #1;
        pushExpect("async_reset");
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        commit_rd = 0; commit_val = 0; commit_rob_id = 0;
        rename_rd = 0; rename_rob_id = 0;
        dec_rs1 = 5'd5; dec_rs2 = 0;
        rob_rs1_ready = 0; rob_rs1_val = 0; rob_rs2_ready = 0; rob_rs2_val = 0;
        modelReset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        query("reset_state", 5'd5, 5'd0);

        applyStimulus("rename3_t7", 0, 0, 0, 3, 7, 0, 1, 3, 0, 0, 0, 0, 0);
        query("x3_pending", 3, 0);
        applyStimulus("x3_rob_ready", 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 32'h55, 0, 0);

        applyStimulus("rename3_t9", 0, 0, 0, 3, 9, 0, 1, 3, 0, 0, 0, 0, 0);
        applyStimulus("commit3_stale", 3, 32'h11, 7, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        query("x3_still_t9", 3, 0);
        applyStimulus("commit3_t9", 3, 32'h22, 9, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        query("x3_free", 3, 3);

        applyStimulus("rename4_t2", 0, 0, 0, 4, 2, 0, 1, 0, 4, 0, 0, 0, 0);
        applyStimulus("commit4_bypass", 4, 32'hAA, 2, 4, 3, 0, 1, 0, 4, 0, 0, 0, 0);
        query("x4_renamed_t3", 4, 4);

        for (int i = 1; i < 32; i++) begin
            applyStimulus("rename_all", 0, 0, 0, i[4:0], i[RW-1:0], 0, 1, i[4:0], 0, 0, 0, 0, 0);
        end
        applyStimulus("flush_commit6", 6, 32'h66, 0, 9, 9, 1, 1, 6, 9, 0, 0, 0, 0);
        for (int i = 0; i < 32; i += 2) begin
            query("after_flush", i[4:0], 5'(i + 1));
        end

        applyStimulus("stall_x8", 8, 32'h88, 5, 8, 5, 0, 0, 8, 8, 0, 0, 0, 0);
        query("x8_unchanged", 8, 8);
        applyStimulus("commit_x0", 0, 32'hFF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        query("x0_zero", 0, 6);

        applyStimulus("rename10_t12", 0, 0, 0, 10, 12, 0, 1, 10, 6, 0, 0, 0, 0);
        asyncReset(10, 6);
        query("post_reset", 10, 6);

        for (int n = 0; n < 1500; n++) begin
            logic [4:0]    c_rd, r_rd, s1, s2;
            logic [RW-1:0] c_id;
            c_rd = 5'($urandom_range(0, 31));
            r_rd = 5'($urandom_range(0, 31));
            s1   = 5'($urandom_range(0, 31));
            s2   = ($urandom_range(0, 3) == 0) ? c_rd : 5'($urandom_range(0, 31));
            c_id = ($urandom_range(0, 1) == 0) ? m_tag[c_rd] : RW'($urandom);
            applyStimulus("random", c_rd, $urandom, c_id, r_rd, RW'($urandom),
                          ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) != 0),
                          s1, s2, ($urandom_range(0, 3) == 0), $urandom,
                          ($urandom_range(0, 3) == 0), $urandom);
        end

        repeat (2) @(negedge clk_in);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
